// File: rtl/alu_issue_sequencer_if.sv
// Request, ALU-drive and result-tracking signals of the ALU issue sequencer.
// The requester side uses the master modport and the sequencer uses the slave modport.
interface alu_issue_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [3:0]       req_cmd;
  logic [1:0]       req_inp_valid;
  logic             req_cin;
  logic [WIDTH-1:0] req_opa;
  logic [WIDTH-1:0] req_opb;
  logic [TAG_W-1:0] req_tag;
  logic             issue_en;

  logic             mode;
  logic             ce;
  logic             cin;
  logic [1:0]       inp_valid;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic [CW-1:0]    count;

  modport master (
    output req_valid, req_mode, req_cmd, req_inp_valid, req_cin,
           req_opa, req_opb, req_tag, issue_en,
    input  req_ready, mode, ce, cin, inp_valid, cmd, opa, opb,
           res_valid, res_tag, count
  );

  modport slave (
    input  req_valid, req_mode, req_cmd, req_inp_valid, req_cin,
           req_opa, req_opb, req_tag, issue_en,
    output req_ready, mode, ce, cin, inp_valid, cmd, opa, opb,
           res_valid, res_tag, count
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Buffers ALU requests in a small FIFO and issues at most one operation per cycle.
// It inserts a hold slot after each multiply and tags each ALU result as it emerges.
module alu_issue_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef struct packed {
    logic             mode;
    logic [3:0]       cmd;
    logic [1:0]       inp_valid;
    logic             cin;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef struct packed {
    logic             valid;
    logic             mul;
    logic [TAG_W-1:0] tag;
  } track_t;

  function automatic logic is_mul(input logic m, input logic [3:0] c);
    return m && (c == 4'b1001 || c == 4'b1010);
  endfunction

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  entry_t        drv;
  logic          ce;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          push;
  logic          pop;
  logic          empty;
  track_t        pipe [3];
  logic          single_hit;
  logic          mul_hit;

  assign empty         = (count == '0);
  assign bus.req_ready = rst_n && (count < CW'(DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state_nxt == ST_ISSUE);
  assign head          = mem[rd_ptr];

  assign wr_entry = '{mode:      bus.req_mode,
                      cmd:       bus.req_cmd,
                      inp_valid: bus.req_inp_valid,
                      cin:       bus.req_cin,
                      opa:       bus.req_opa,
                      opb:       bus.req_opb,
                      tag:       bus.req_tag};

  // A scheduled hold always wins, so ISSUE_EN cannot cancel the slot after a multiply.
  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = ST_IDLE;
    if (state == ST_ISSUE && is_mul(drv.mode, drv.cmd)) begin
      state_nxt = ST_HOLD;
    end else if (bus.issue_en && !empty) begin
      state_nxt = ST_ISSUE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the occupancy count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ce    <= 1'b0;
      drv   <= '0;
    end else begin
      state <= state_nxt;
      case (state_nxt)
        ST_ISSUE: begin
          ce  <= 1'b1;
          drv <= head;
        end
        ST_HOLD: begin
          // MODE and CMD are kept so the ALU output mux stays on the multiply path.
          ce            <= 1'b0;
          drv.inp_valid <= '0;
          drv.cin       <= 1'b0;
          drv.opa       <= '0;
          drv.opb       <= '0;
          drv.tag       <= '0;
        end
        default: begin
          ce  <= 1'b0;
          drv <= '0;
        end
      endcase
    end
  end

  assign bus.ce        = ce;
  assign bus.mode      = drv.mode;
  assign bus.cmd       = drv.cmd;
  assign bus.inp_valid = drv.inp_valid;
  assign bus.cin       = drv.cin;
  assign bus.opa       = drv.opa;
  assign bus.opb       = drv.opb;

  // Each port-cycle enters the pipe; single ops surface from stage 1 and multiplies from stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: ce, mul: is_mul(drv.mode, drv.cmd), tag: drv.tag};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  assign single_hit    = pipe[1].valid && !pipe[1].mul;
  assign mul_hit       = pipe[2].valid && pipe[2].mul;
  assign bus.res_valid = single_hit || mul_hit;
  assign bus.res_tag   = mul_hit    ? pipe[2].tag :
                         single_hit ? pipe[1].tag : '0;
  assign bus.count     = count;
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer: reset, latency, multiply hold, full FIFO,
// pointer wrap under stalls and reset while operations are in flight.
module tb_alu_issue_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer_if #(.WIDTH(8), .DEPTH(4), .TAG_W(4)) bus ();

  alu_issue_sequencer #(.WIDTH(8), .DEPTH(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (rst_n && dut.single_hit && dut.mul_hit) begin
      failed++;
      $display("FAIL result_collision: single and multiply results both present at %0t", $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    bus.req_mode      = m;
    bus.req_cmd       = c;
    bus.req_inp_valid = iv;
    bus.req_cin       = 1'b0;
    bus.req_opa       = a;
    bus.req_opb       = b;
    bus.req_tag       = t;
  endtask

  task automatic test_reset();
    bus.issue_en  = 1'b1;
    bus.req_valid = 1'b1;
    set_req(1'b1, 4'd0, 2'b11, 8'h11, 8'h22, 4'd7);
    rst_n = 1'b0;
    repeat (3) tick();
    tests++; if ({bus.ce, bus.mode, bus.cmd, bus.inp_valid, bus.cin, bus.opa, bus.opb} !== 25'd0) begin
      failed++; $display("FAIL reset_alu_ports: got %h required 0", {bus.ce, bus.mode, bus.cmd, bus.inp_valid, bus.cin, bus.opa, bus.opb}); end
    tests++; if ({bus.res_valid, bus.res_tag} !== 5'd0) begin
      failed++; $display("FAIL reset_result: got %h required 0", {bus.res_valid, bus.res_tag}); end
    tests++; if (bus.count !== 3'd0) begin
      failed++; $display("FAIL reset_count: got %0d required 0", bus.count); end
    tests++; if (bus.req_ready !== 1'b0) begin
      failed++; $display("FAIL reset_ready: got %b required 0", bus.req_ready); end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tests++; if (bus.req_ready !== 1'b1) begin
      failed++; $display("FAIL ready_after_reset: got %b required 1", bus.req_ready); end
  endtask

  task automatic test_single_add();
    bus.issue_en = 1'b1;
    set_req(1'b1, 4'd0, 2'b11, 8'h05, 8'h03, 4'd3);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tests++; if (bus.count !== 3'd1 || bus.ce !== 1'b0) begin
      failed++; $display("FAIL add_buffered: count %0d ce %b required 1 0", bus.count, bus.ce); end
    tick();
    tests++; if ({bus.ce, bus.mode, bus.cmd, bus.inp_valid, bus.opa, bus.opb} !== {1'b1, 1'b1, 4'd0, 2'b11, 8'h05, 8'h03}) begin
      failed++; $display("FAIL add_issue: got %h required %h", {bus.ce, bus.mode, bus.cmd, bus.inp_valid, bus.opa, bus.opb},
                         {1'b1, 1'b1, 4'd0, 2'b11, 8'h05, 8'h03}); end
    tick();
    tests++; if (bus.ce !== 1'b0 || bus.res_valid !== 1'b0) begin
      failed++; $display("FAIL add_n1: ce %b res_valid %b required 0 0", bus.ce, bus.res_valid); end
    tick();
    tests++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd3) begin
      failed++; $display("FAIL add_result: valid %b tag %0d required 1 3", bus.res_valid, bus.res_tag); end
    tick();
    tests++; if (bus.res_valid !== 1'b0 || bus.res_tag !== 4'd0) begin
      failed++; $display("FAIL add_result_end: valid %b tag %0d required 0 0", bus.res_valid, bus.res_tag); end
  endtask

  task automatic test_mul_then_add();
    bus.issue_en = 1'b1;
    set_req(1'b1, 4'd9, 2'b11, 8'h04, 8'h06, 4'd1);
    bus.req_valid = 1'b1;
    tick();
    set_req(1'b1, 4'd0, 2'b11, 8'h02, 8'h01, 4'd2);
    tick();
    bus.req_valid = 1'b0;
    tests++; if ({bus.ce, bus.mode, bus.cmd, bus.opa} !== {1'b1, 1'b1, 4'd9, 8'h04}) begin
      failed++; $display("FAIL mul_issue: got %h required %h", {bus.ce, bus.mode, bus.cmd, bus.opa}, {1'b1, 1'b1, 4'd9, 8'h04}); end
    tick();
    tests++; if ({bus.ce, bus.mode, bus.cmd, bus.inp_valid, bus.opa, bus.opb} !== {1'b0, 1'b1, 4'd9, 2'b00, 16'h0000}) begin
      failed++; $display("FAIL mul_hold: got %h required %h", {bus.ce, bus.mode, bus.cmd, bus.inp_valid, bus.opa, bus.opb},
                         {1'b0, 1'b1, 4'd9, 2'b00, 16'h0000}); end
    tests++; if (bus.count !== 3'd1) begin
      failed++; $display("FAIL hold_no_pop: count %0d required 1", bus.count); end
    tick();
    tests++; if ({bus.ce, bus.cmd, bus.opa} !== {1'b1, 4'd0, 8'h02}) begin
      failed++; $display("FAIL add_after_hold: got %h required %h", {bus.ce, bus.cmd, bus.opa}, {1'b1, 4'd0, 8'h02}); end
    tick();
    tests++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd1) begin
      failed++; $display("FAIL mul_result: valid %b tag %0d required 1 1", bus.res_valid, bus.res_tag); end
    tests++; if ({bus.ce, bus.mode, bus.cmd} !== 6'd0) begin
      failed++; $display("FAIL idle_ports: got %h required 0", {bus.ce, bus.mode, bus.cmd}); end
    tick();
    tests++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd2) begin
      failed++; $display("FAIL add2_result: valid %b tag %0d required 1 2", bus.res_valid, bus.res_tag); end
    tick();
    tests++; if (bus.res_valid !== 1'b0) begin
      failed++; $display("FAIL mul_add_drain: valid %b required 0", bus.res_valid); end
  endtask

  task automatic test_full();
    bus.issue_en  = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 4'd0, 2'b11, 8'(i), 8'h00, 4'(i));
      tick();
    end
    tests++; if (bus.count !== 3'd4 || bus.req_ready !== 1'b0) begin
      failed++; $display("FAIL full: count %0d ready %b required 4 0", bus.count, bus.req_ready); end
    set_req(1'b1, 4'd0, 2'b11, 8'd4, 8'h00, 4'd4);
    tick();
    bus.req_valid = 1'b0;
    tests++; if (bus.count !== 3'd4) begin
      failed++; $display("FAIL fifth_rejected: count %0d required 4", bus.count); end
    bus.issue_en = 1'b1;
    tick();
    tests++; if (bus.ce !== 1'b1 || bus.opa !== 8'd0 || bus.count !== 3'd3 || bus.req_ready !== 1'b1) begin
      failed++; $display("FAIL first_pop: ce %b opa %0d count %0d ready %b required 1 0 3 1",
                         bus.ce, bus.opa, bus.count, bus.req_ready); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 3) begin
        tests++; if (bus.ce !== 1'b1 || bus.opa !== 8'(k)) begin
          failed++; $display("FAIL full_order[%0d]: ce %b opa %0d required 1 %0d", k, bus.ce, bus.opa, k); end
      end
      if (k >= 2) begin
        tests++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'(k - 2)) begin
          failed++; $display("FAIL full_result[%0d]: valid %b tag %0d required 1 %0d", k, bus.res_valid, bus.res_tag, k - 2); end
      end
    end
    tick();
    tests++; if (bus.res_valid !== 1'b0 || bus.count !== 3'd0) begin
      failed++; $display("FAIL full_drain: valid %b count %0d required 0 0", bus.res_valid, bus.count); end
  endtask

  task automatic test_pointer_wrap();
    int   idx = 0;
    int   exp_tag = 0;
    logic acc;
    for (int c = 0; c < 60; c++) begin
      if (idx < 10) begin
        set_req(1'b1, 4'd0, 2'b11, 8'(idx), 8'h00, 4'(idx));
        bus.req_valid = 1'b1;
      end else begin
        bus.req_valid = 1'b0;
      end
      bus.issue_en = (c % 2 == 0);
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (acc) idx++;
      tests++; if (bus.count > 3'd4) begin
        failed++; $display("FAIL wrap_count: count %0d exceeds 4", bus.count); end
      if (bus.res_valid) begin
        tests++; if (bus.res_tag !== 4'(exp_tag)) begin
          failed++; $display("FAIL wrap_order: tag %0d required %0d", bus.res_tag, exp_tag); end
        exp_tag++;
      end
    end
    bus.req_valid = 1'b0;
    bus.issue_en  = 1'b1;
    tests++; if (exp_tag != 10 || bus.count !== 3'd0) begin
      failed++; $display("FAIL wrap_total: results %0d count %0d required 10 0", exp_tag, bus.count); end
  endtask

  task automatic test_reset_mid_op();
    bus.issue_en  = 1'b1;
    bus.req_valid = 1'b1;
    set_req(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 4'd5);
    tick();
    set_req(1'b1, 4'd0, 2'b11, 8'h02, 8'h01, 4'd6);
    tick();
    set_req(1'b1, 4'd0, 2'b11, 8'h03, 8'h01, 4'd7);
    tick();
    bus.issue_en = 1'b0;
    set_req(1'b1, 4'd0, 2'b11, 8'h04, 8'h01, 4'd8);
    tick();
    bus.req_valid = 1'b0;
    tests++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd5 || bus.count !== 3'd2) begin
      failed++; $display("FAIL pre_reset: valid %b tag %0d count %0d required 1 5 2", bus.res_valid, bus.res_tag, bus.count); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.res_valid !== 1'b0 || bus.count !== 3'd0 || bus.ce !== 1'b0 || bus.req_ready !== 1'b0) begin
      failed++; $display("FAIL async_reset: valid %b count %0d ce %b ready %b required 0 0 0 0",
                         bus.res_valid, bus.count, bus.ce, bus.req_ready); end
    tick();
    rst_n = 1'b1;
    bus.issue_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++; if (bus.res_valid !== 1'b0 || bus.count !== 3'd0 || bus.ce !== 1'b0) begin
        failed++; $display("FAIL post_reset[%0d]: valid %b count %0d ce %b required 0 0 0", k, bus.res_valid, bus.count, bus.ce); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.issue_en  = 1'b0;
    set_req(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 4'd0);
    test_reset();
    test_single_add();
    test_mul_then_add();
    test_full();
    test_pointer_wrap();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
